// File: rtl/sram_ctrl.sv
// Byte-wide CPU-bus slave driving an external asynchronous 16-bit SRAM.
// Single-cycle requests become timed strobe sequences while ready stalls the CPU.
module sram_ctrl #(
    parameter int ADDR_WIDTH      = 16,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cs,
    input  logic                       rd_req,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [7:0]                 wr_data,
    output logic [7:0]                 rd_data,
    output logic                       ready,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    input  logic [15:0]                sram_dq_in,
    output logic [15:0]                sram_dq_out,
    output logic                       sram_dq_oe,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n,
    output logic                       sram_ub_n,
    output logic                       sram_lb_n
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t                       state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [7:0]                   rd_data_q;
    logic                         ready_q;
    logic [SRAM_ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]                  dq_out_q;
    logic                         dq_oe_q;
    logic                         ce_n_q;
    logic                         oe_n_q;
    logic                         we_n_q;
    logic                         ub_n_q;
    logic                         lb_n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_data_q <= '0;
            ready_q   <= 1'b1;
            addr_q    <= '0;
            dq_out_q  <= '0;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs && (rd_req || wr_en)) begin
                        addr_q  <= SRAM_ADDR_WIDTH'(addr[ADDR_WIDTH-1:1]);
                        ub_n_q  <= ~addr[0];
                        lb_n_q  <= addr[0];
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        ce_n_q  <= 1'b0;
                        // A simultaneous read is dropped: the write takes priority.
                        if (wr_en) begin
                            dq_out_q <= {wr_data, wr_data};
                            dq_oe_q  <= 1'b1;
                            state_q  <= WR_SETUP;
                        end else begin
                            oe_n_q  <= 1'b0;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt_q == LAST) begin
                        rd_data_q <= ub_n_q ? sram_dq_in[7:0] : sram_dq_in[15:8];
                        ce_n_q    <= 1'b1;
                        oe_n_q    <= 1'b1;
                        ub_n_q    <= 1'b1;
                        lb_n_q    <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WR_SETUP: begin
                    we_n_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WR_PULSE;
                end
                WR_PULSE: begin
                    // Address, data and dq_oe stay put until after WR_HOLD.
                    if (cnt_q == LAST) begin
                        we_n_q  <= 1'b1;
                        state_q <= WR_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WR_HOLD: begin
                    ce_n_q  <= 1'b1;
                    ub_n_q  <= 1'b1;
                    lb_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data     = rd_data_q;
    assign ready       = ready_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural asynchronous SRAM model.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;

    logic [15:0] mem [0:4095];

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_WIDTH(16), .SRAM_ADDR_WIDTH(18), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .rd_req(rd_req), .wr_en(wr_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // SRAM model: reads are combinational, writes land while we_n is low.
    always_comb begin
        sram_dq_in = 16'hDEAD;
        if (!sram_ce_n && !sram_oe_n) sram_dq_in = mem[sram_addr[11:0]];
    end

    always @(posedge clk) begin
        if (reset) begin
            mem[12'h91A] <= 16'h3C5A;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) mem[sram_addr[11:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[11:0]][15:8] <= sram_dq_out[15:8];
        end
    end

    // Bus invariants checked every cycle once out of the first reset.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (!sram_oe_n && sram_dq_oe) begin
                bad++;
                $display("FAIL invariant_oe_vs_dq_oe: oe_n=%b dq_oe=%b required not both active", sram_oe_n, sram_dq_oe);
            end
            total++;
            if (!sram_we_n && (sram_ce_n || !sram_dq_oe)) begin
                bad++;
                $display("FAIL invariant_we: we_n=0 ce_n=%b dq_oe=%b required ce_n=0 dq_oe=1", sram_ce_n, sram_dq_oe);
            end
        end
    end

    // Called at a negedge; drives one request pulse, then observes until ready returns.
    task automatic do_access(input logic r, input logic w, input logic c,
                             input logic [15:0] a, input logic [7:0] d,
                             output int rdy_low, output int we_low, output int we_first,
                             output int oe_low, output int ce_low,
                             output logic [17:0] cap_addr, output logic [15:0] cap_dq,
                             output logic cap_ub, output logic cap_lb);
        cs = c; rd_req = r; wr_en = w; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; rd_req = 1'b0; wr_en = 1'b0;
        rdy_low = 0; we_low = 0; we_first = -1; oe_low = 0; ce_low = 0;
        cap_addr = sram_addr; cap_dq = sram_dq_out; cap_ub = sram_ub_n; cap_lb = sram_lb_n;
        for (int i = 1; i <= 20; i++) begin
            if (ready === 1'b1) break;
            rdy_low++;
            if (!sram_we_n) begin
                we_low++;
                if (we_first < 0) we_first = i;
            end
            if (!sram_oe_n) oe_low++;
            if (!sram_ce_n) ce_low++;
            @(negedge clk);
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL access_timeout: ready=%b required 1 within 20 cycles", ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({ready, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 6'b111111) begin
            bad++;
            $display("FAIL reset_strobes: ready,ce,oe,we,ub,lb=%b required 111111",
                     {ready, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
        end
        total++;
        if (sram_dq_oe !== 1'b0 || rd_data !== 8'h00 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_data: dq_oe=%b rd_data=%h addr=%h dq_out=%h required 0 0 0 0",
                     sram_dq_oe, rd_data, sram_addr, sram_dq_out);
        end
    endtask

    task automatic test_read(input logic [15:0] a, input logic [7:0] exp_d);
        int rl, wl, wf, ol, cl;
        logic [17:0] ca; logic [15:0] cd; logic cu, cb;
        do_access(1'b1, 1'b0, 1'b1, a, 8'h00, rl, wl, wf, ol, cl, ca, cd, cu, cb);
        total++;
        if (rd_data !== exp_d) begin
            bad++;
            $display("FAIL read_data addr=%h: got %h required %h", a, rd_data, exp_d);
        end
        total++;
        if (rl != 2 || ol != 2 || wl != 0) begin
            bad++;
            $display("FAIL read_timing addr=%h: ready_low=%0d oe_low=%0d we_low=%0d required 2 2 0", a, rl, ol, wl);
        end
        total++;
        if (ca !== 18'(a[15:1]) || cu !== ~a[0] || cb !== a[0]) begin
            bad++;
            $display("FAIL read_addr addr=%h: sram_addr=%h ub_n=%b lb_n=%b required %h %b %b",
                     a, ca, cu, cb, 18'(a[15:1]), ~a[0], a[0]);
        end
    endtask

    task automatic test_write();
        int rl, wl, wf, ol, cl;
        logic [17:0] ca; logic [15:0] cd; logic cu, cb;
        do_access(1'b0, 1'b1, 1'b1, 16'h1235, 8'hA5, rl, wl, wf, ol, cl, ca, cd, cu, cb);
        total++;
        if (ca !== 18'h091A || cu !== 1'b0 || cb !== 1'b1 || cd !== 16'hA5A5) begin
            bad++;
            $display("FAIL write_setup: addr=%h ub_n=%b lb_n=%b dq_out=%h required 091a 0 1 a5a5", ca, cu, cb, cd);
        end
        total++;
        if (wl != 2 || wf != 2) begin
            bad++;
            $display("FAIL write_we_pulse: we_low=%0d first=%0d required 2 2", wl, wf);
        end
        total++;
        if (rl != 4 || ol != 0) begin
            bad++;
            $display("FAIL write_ready: ready_low=%0d oe_low=%0d required 4 0", rl, ol);
        end
        total++;
        if (sram_dq_oe !== 1'b0 || sram_ce_n !== 1'b1 || sram_ub_n !== 1'b1) begin
            bad++;
            $display("FAIL write_release: dq_oe=%b ce_n=%b ub_n=%b required 0 1 1", sram_dq_oe, sram_ce_n, sram_ub_n);
        end
    endtask

    task automatic test_collision();
        int rl, wl, wf, ol, cl;
        logic [17:0] ca; logic [15:0] cd; logic cu, cb;
        do_access(1'b1, 1'b1, 1'b1, 16'h0010, 8'h77, rl, wl, wf, ol, cl, ca, cd, cu, cb);
        total++;
        if (ol != 0 || wl != 2 || rl != 4 || ca !== 18'h0008 || cb !== 1'b0) begin
            bad++;
            $display("FAIL collision: oe_low=%0d we_low=%0d ready_low=%0d addr=%h lb_n=%b required 0 2 4 0008 0",
                     ol, wl, rl, ca, cb);
        end
        @(negedge clk);
        test_read(16'h0010, 8'h77);
    endtask

    task automatic test_ignored();
        int ce_cnt = 0, we_cnt = 0, rdy_low = 0;
        cs = 1'b1; rd_req = 1'b1; addr = 16'h1234;
        @(negedge clk);
        cs = 1'b1; rd_req = 1'b0; wr_en = 1'b1; addr = 16'h0040; wr_data = 8'h99;
        for (int i = 0; i < 8; i++) begin
            if (!sram_ce_n) ce_cnt++;
            if (!sram_we_n) we_cnt++;
            if (!ready) rdy_low++;
            @(negedge clk);
            cs = 1'b0; wr_en = 1'b0;
        end
        total++;
        if (ce_cnt != 2 || we_cnt != 0 || rdy_low != 2 || rd_data !== 8'h5A) begin
            bad++;
            $display("FAIL busy_ignore: ce_low=%0d we_low=%0d ready_low=%0d rd_data=%h required 2 0 2 5a",
                     ce_cnt, we_cnt, rdy_low, rd_data);
        end
        ce_cnt = 0; rdy_low = 0;
        cs = 1'b0; rd_req = 1'b1; wr_en = 1'b1; addr = 16'h0040;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!sram_ce_n || !sram_oe_n || !sram_we_n) ce_cnt++;
            if (!ready) rdy_low++;
        end
        rd_req = 1'b0; wr_en = 1'b0;
        total++;
        if (ce_cnt != 0 || rdy_low != 0 || sram_addr !== 18'h091A) begin
            bad++;
            $display("FAIL cs_low_ignore: strobes=%0d ready_low=%0d sram_addr=%h required 0 0 091a",
                     ce_cnt, rdy_low, sram_addr);
        end
    endtask

    task automatic test_reset_mid_write();
        cs = 1'b1; wr_en = 1'b1; addr = 16'h0100; wr_data = 8'h11;
        @(negedge clk);
        cs = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        total++;
        if (sram_we_n !== 1'b0) begin
            bad++;
            $display("FAIL mid_write_pulse: we_n=%b required 0", sram_we_n);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({sram_we_n, sram_ce_n, sram_dq_oe, ready, rd_data} !== {4'b1101, 8'h00}) begin
            bad++;
            $display("FAIL mid_write_reset: we_n=%b ce_n=%b dq_oe=%b ready=%b rd_data=%h required 1 1 0 1 00",
                     sram_we_n, sram_ce_n, sram_dq_oe, ready, rd_data);
        end
        reset = 1'b0;
        @(negedge clk);
        test_read(16'h1234, 8'h5A);
    endtask

    initial begin
        test_reset();
        test_read(16'h1234, 8'h5A);
        test_read(16'h1235, 8'h3C);
        test_write();
        test_read(16'h1235, 8'hA5);
        test_read(16'h1234, 8'h5A);
        test_collision();
        test_ignored();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, required finish");
        $fatal(1, "timeout");
    end

endmodule
